// File: rtl/lab1_imul_int_mul_var_skip.sv
// rtl/lab1_imul_int_mul_var_skip.sv - variable-latency iterative integer multiplier with zero skipping
//
// Purpose:
//   Takes an operand pair {a, b} on a val/rdy input stream. Returns the low
//   p_nbits of a*b on a val/rdy output stream. Each CALC iteration does one
//   of two things:
//     - adds the shifted multiplicand when b_reg[0] is set, or
//     - skips the run of trailing zeros in the low p_win bits of b_reg.
//   Iteration stops as soon as the remaining multiplier bits are all zero.
//
// Configuration:
//   LAB1_IMUL_INT_MUL_VAR_SKIP_EN - when defined, zero skipping is enabled with
//   shifts of up to p_win bits. When undefined, every iteration shifts by one
//   bit. Products are identical in both builds; only latency differs.
//
// Parameters:
//   p_nbits      operand/result width (>= 2)
//   p_win        skip window width in bits (1..p_nbits)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   istream_val  request valid
//   istream_rdy  request ready (only in IDLE, forced low during reset)
//   istream_msg  request operands {a, b}
//   ostream_val  response valid (only in DONE, forced low during reset)
//   ostream_rdy  response ready
//   ostream_msg  product a*b mod 2^p_nbits

module lab1_imul_int_mul_var_skip #(
    parameter int p_nbits = 32,
    parameter int p_win   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [2*p_nbits-1:0] istream_msg,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [p_nbits-1:0]   ostream_msg
);

    localparam int SW = $clog2(p_win + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] a_q, a_d;
    logic [p_nbits-1:0] b_q, b_d;
    logic [p_nbits-1:0] result_q, result_d;

    logic [SW-1:0]      shamt;
    logic [p_nbits-1:0] b_shifted;
    logic [p_nbits-1:0] req_a;
    logic [p_nbits-1:0] req_b;

    assign req_a = istream_msg[2*p_nbits-1:p_nbits];
    assign req_b = istream_msg[p_nbits-1:0];

`ifdef LAB1_IMUL_INT_MUL_VAR_SKIP_EN
    logic [p_win-1:0] window;
    logic [SW-1:0]    tz_count;

    assign window = b_q[p_win-1:0];

    // Trailing-zero count of the window. Scanning from the top down lets the
    // lowest set bit win. An all-zero window keeps the default of p_win.
    always_comb begin
        tz_count = SW'(p_win);
        for (int i = p_win - 1; i >= 0; i--) begin
            if (window[i]) begin
                tz_count = SW'(i);
            end
        end
    end

    // A set LSB always means add-then-shift-by-one. Otherwise skip the
    // zero run. tz_count is never 0 here because window[0] is clear.
    always_comb begin
        shamt = b_q[0] ? SW'(1) : tz_count;
    end
`else
    always_comb begin
        shamt = SW'(1);
    end
`endif

    assign b_shifted = b_q >> shamt;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (istream_val) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    result_d = '0;
                    state_d  = (req_b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (b_q[0]) begin
                    result_d = result_q + a_q;
                end
                a_d = a_q << shamt;
                b_d = b_shifted;
                if (b_shifted == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // Reset gating keeps istream_rdy low while reset is held, even though the
    // state register already reads IDLE.
    assign istream_rdy = (state_q == IDLE) && !reset;
    assign ostream_val = (state_q == DONE) && !reset;
    assign ostream_msg = result_q;

endmodule

// File: tb/tb_lab1_imul_int_mul_var_skip.sv
// tb/tb_lab1_imul_int_mul_var_skip.sv - directed self-checking bench for lab1_imul_int_mul_var_skip

module tb_lab1_imul_int_mul_var_skip;

    logic        clk;
    logic        reset;
    logic        istream_val;
    logic        istream_rdy;
    logic [63:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] ostream_msg;

    int n_checks;
    int n_errors;

    lab1_imul_int_mul_var_skip #(
        .p_nbits(32),
        .p_win  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .istream_val(istream_val),
        .istream_rdy(istream_rdy),
        .istream_msg(istream_msg),
        .ostream_val(ostream_val),
        .ostream_rdy(ostream_rdy),
        .ostream_msg(ostream_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Issues one request and measures accept-to-valid
    // latency; the accept edge counts as 1, so latency = N + 1. It then
    // optionally stalls the response for `hold` cycles before releasing it.
    task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int n_iter, input int hold);
        int t;
        int lat;
        t = 0;
        while (!istream_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_rdy"}, 64'(istream_rdy), 64'd1);
        istream_val = 1'b1;
        istream_msg = {a, b};
        ostream_rdy = (hold == 0);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        istream_msg = '0;
        lat = 1;
        @(negedge clk);
        while (!ostream_val && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(n_iter + 1));
        check_eq({tag, "_msg"}, 64'(ostream_msg), 64'(exp));
        check_eq({tag, "_irdy_done"}, 64'(istream_rdy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_val"}, 64'(ostream_val), 64'd1);
            check_eq({tag, "_hold_msg"}, 64'(ostream_msg), 64'(exp));
            check_eq({tag, "_hold_irdy"}, 64'(istream_rdy), 64'd0);
        end
        ostream_rdy = 1'b1;
        @(negedge clk);
        check_eq({tag, "_post_val"}, 64'(ostream_val), 64'd0);
        check_eq({tag, "_post_irdy"}, 64'(istream_rdy), 64'd1);
    endtask

`ifdef LAB1_IMUL_INT_MUL_VAR_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        istream_val = 1'b0;
        istream_msg = '0;
        ostream_rdy = 1'b1;

        repeat (3) @(negedge clk);
        check_eq("rst_irdy", 64'(istream_rdy), 64'd0);
        check_eq("rst_oval", 64'(ostream_val), 64'd0);
        check_eq("rst_msg", 64'(ostream_msg), 64'd0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_irdy", 64'(istream_rdy), 64'd1);
        check_eq("post_rst_oval", 64'(ostream_val), 64'd0);
        @(negedge clk);

        run_req("basic_3x5", 32'd3, 32'd5, 32'd15, 3, 0);
        run_req("win_1x100", 32'd1, 32'h100, 32'h100, SKIP ? 2 : 9, 0);
        run_req("wrap_2x8000", 32'd2, 32'h8000_0000, 32'h0, SKIP ? 5 : 32, 0);
        run_req("worst_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32, 0);
        run_req("bzero_7x0", 32'd7, 32'd0, 32'd0, 0, 0);
        run_req("bp_6x7", 32'd6, 32'd7, 32'd42, 3, 5);
        run_req("b2b_ffff", 32'hFFFF, 32'hFFFF, 32'hFFFE_0001, 16, 0);

        // Reset in the middle of CALC for 3*0xFF (8 iterations).
        istream_val = 1'b1;
        istream_msg = {32'd3, 32'hFF};
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        istream_msg = '0;
        repeat (3) @(negedge clk);
        check_eq("mid_calc_oval", 64'(ostream_val), 64'd0);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_oval", 64'(ostream_val), 64'd0);
        check_eq("rst_mid_irdy", 64'(istream_rdy), 64'd0);
        check_eq("rst_mid_msg", 64'(ostream_msg), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_rel_irdy", 64'(istream_rdy), 64'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("no_resp_after_rst", 64'(ostream_val), 64'd0);
        end
        run_req("fresh_4x4", 32'd4, 32'd4, 32'd16, SKIP ? 2 : 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
